// File: rtl/fir_bus_master_pkg.sv
// Shared constants and state encoding for the FIR register-bus master.
package fir_bus_pkg;

  localparam logic [1:0] ADDR_COEF = 2'd0;
  localparam logic [1:0] ADDR_X    = 2'd1;
  localparam logic [1:0] ADDR_CTRL = 2'd2;
  localparam logic [1:0] ADDR_ID   = 2'd0;

  localparam int DEFAULT_ID = 15;

  typedef enum logic [3:0] {
    ID_REQ   = 4'd0,
    ID_WAIT  = 4'd1,
    HALT     = 4'd2,
    IDLE     = 4'd3,
    WR_COEF  = 4'd4,
    WR_X     = 4'd5,
    CTRL_ON  = 4'd6,
    WAIT     = 4'd7,
    RD_REQ   = 4'd8,
    RD_CAP   = 4'd9,
    CTRL_OFF = 4'd10,
    OUT      = 4'd11
  } state_e;

endpackage

// File: rtl/fir_bus_master_if.sv
// Register bus between the FIR bus master (initiator) and the FIR slave.
interface fir_bus_master_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  cs;
  logic                  write;
  logic                  read;
  logic [1:0]            addr;
  logic [DATA_WIDTH-1:0] write_data;
  logic [DATA_WIDTH-1:0] read_data;

  modport master (
    output cs, write, read, addr, write_data,
    input  read_data
  );

  modport slave (
    input  cs, write, read, addr, write_data,
    output read_data
  );
endinterface

// File: rtl/fir_bus_master_bus_if.sv
// Registered strobe generator: turns a one-cycle op request into a clean
// single-cycle bus transaction, with addr/data forced to 0 when idle.
module fir_bus_if #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_req_rd,
  input  logic                  i_req_wr,
  input  logic [1:0]            i_req_addr,
  input  logic [DATA_WIDTH-1:0] i_req_data,
  fir_bus_master_if.master      bus
);

  logic w_rd;
  logic w_wr;

  // a read request wins if both are ever raised, keeping one strobe per cycle
  assign w_rd = i_req_rd;
  assign w_wr = i_req_wr & ~i_req_rd;

  // register the strobes so the bus is glitch-free and cleared by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.cs         <= 1'b0;
      bus.read       <= 1'b0;
      bus.write      <= 1'b0;
      bus.addr       <= '0;
      bus.write_data <= '0;
    end else begin
      bus.cs         <= w_rd | w_wr;
      bus.read       <= w_rd;
      bus.write      <= w_wr;
      bus.addr       <= (w_rd | w_wr) ? i_req_addr : 2'd0;
      bus.write_data <= w_wr ? i_req_data : '0;
    end
  end

endmodule

// File: rtl/fir_bus_master.sv
// FIR bus master: probes the slave ID, then turns coefficient/sample streams
// into register transactions and returns each FIR result as a stream beat.
module fir_bus_master
  import fir_bus_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int FIR_LATENCY = 4,
  parameter int EXPECTED_ID = DEFAULT_ID
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  coef_valid,
  output logic                  coef_ready,
  input  logic [DATA_WIDTH-1:0] coef_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  id_ok,
  output logic                  id_err,
  fir_bus_master_if.master      bus
);

  localparam int CNT_W = $clog2(FIR_LATENCY + 1);

  state_e                r_state;
  state_e                w_next;
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_WIDTH-1:0] r_m_data;
  logic                  r_id_ok;
  logic                  r_id_err;
  logic                  w_id_match;

  logic                  w_req_rd;
  logic                  w_req_wr;
  logic [1:0]            w_req_addr;
  logic [DATA_WIDTH-1:0] w_req_data;

  assign w_id_match = (bus.read_data == DATA_WIDTH'(EXPECTED_ID));

  // Bus ops are requested on the transition into a state, so the registered
  // strobe is on the bus while the FSM sits in that state.
  always_comb begin
    w_next     = r_state;
    w_req_rd   = 1'b0;
    w_req_wr   = 1'b0;
    w_req_addr = 2'd0;
    w_req_data = '0;
    case (r_state)
      // stay until the ID read has actually been driven for one cycle
      ID_REQ: begin
        if (bus.read) begin
          w_next = ID_WAIT;
        end else begin
          w_req_rd   = 1'b1;
          w_req_addr = ADDR_ID;
        end
      end
      ID_WAIT:  w_next = w_id_match ? IDLE : HALT;
      HALT:     w_next = HALT;
      IDLE: begin
        if (coef_valid) begin
          w_next     = WR_COEF;
          w_req_wr   = 1'b1;
          w_req_addr = ADDR_COEF;
          w_req_data = coef_data;
        end else if (s_valid) begin
          w_next     = WR_X;
          w_req_wr   = 1'b1;
          w_req_addr = ADDR_X;
          w_req_data = s_data;
        end
      end
      WR_COEF:  w_next = IDLE;
      WR_X: begin
        w_next     = CTRL_ON;
        w_req_wr   = 1'b1;
        w_req_addr = ADDR_CTRL;
        w_req_data = DATA_WIDTH'(1);
      end
      CTRL_ON:  w_next = WAIT;
      WAIT: begin
        if (r_cnt == CNT_W'(1)) begin
          w_next     = RD_REQ;
          w_req_rd   = 1'b1;
          w_req_addr = ADDR_X;
        end
      end
      RD_REQ:   w_next = RD_CAP;
      RD_CAP: begin
        w_next     = CTRL_OFF;
        w_req_wr   = 1'b1;
        w_req_addr = ADDR_CTRL;
        w_req_data = '0;
      end
      CTRL_OFF: w_next = OUT;
      OUT:      w_next = m_ready ? IDLE : OUT;
      default:  w_next = ID_REQ;
    endcase
  end

  // state register; reset abandons any transaction and restarts the ID probe
  always_ff @(posedge clk) begin
    if (reset) r_state <= ID_REQ;
    else       r_state <= w_next;
  end

  // WAIT down-counter: loaded on the control=1 write, one WAIT cycle per count
  always_ff @(posedge clk) begin
    if (reset)                   r_cnt <= '0;
    else if (r_state == CTRL_ON) r_cnt <= CNT_W'(FIR_LATENCY);
    else if (r_state == WAIT)    r_cnt <= r_cnt - CNT_W'(1);
  end

  // sticky ID probe outcome, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      r_id_ok  <= 1'b0;
      r_id_err <= 1'b0;
    end else if (r_state == ID_WAIT) begin
      r_id_ok  <= w_id_match;
      r_id_err <= ~w_id_match;
    end
  end

  // capture the slave's registered result the cycle after the read strobe
  always_ff @(posedge clk) begin
    if (reset)                  r_m_data <= '0;
    else if (r_state == RD_CAP) r_m_data <= bus.read_data;
  end

  fir_bus_if #(.DATA_WIDTH(DATA_WIDTH)) u_bus (
    .clk        (clk),
    .reset      (reset),
    .i_req_rd   (w_req_rd),
    .i_req_wr   (w_req_wr),
    .i_req_addr (w_req_addr),
    .i_req_data (w_req_data),
    .bus        (bus)
  );

  assign coef_ready = (r_state == IDLE);
  assign s_ready    = (r_state == IDLE);
  assign m_valid    = (r_state == OUT);
  assign m_data     = r_m_data;
  assign id_ok      = r_id_ok;
  assign id_err     = r_id_err;

endmodule

// File: tb/tb_fir_bus_master.sv
// Directed bench for fir_bus_master with a small registered slave model.
module tb_fir_bus_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        coef_valid = 1'b0;
  logic        coef_ready;
  logic [31:0] coef_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_data = '0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [31:0] m_data;
  logic        id_ok;
  logic        id_err;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  logic [31:0] id_val     = 32'd15;
  logic [31:0] result_val = 32'h1234;

  typedef struct {
    logic        w;
    logic        r;
    logic [1:0]  a;
    logic [31:0] d;
    int          c;
  } tr_t;
  tr_t lg[$];

  fir_bus_master_if #(.DATA_WIDTH(32)) bus ();

  fir_bus_master #(.DATA_WIDTH(32), .FIR_LATENCY(4), .EXPECTED_ID(15)) dut (
    .clk        (clk),
    .reset      (reset),
    .coef_valid (coef_valid),
    .coef_ready (coef_ready),
    .coef_data  (coef_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .id_ok      (id_ok),
    .id_err     (id_err),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // slave model: registered read data, 0 when no read is strobed
  always @(posedge clk) begin
    if (bus.cs && bus.read)
      bus.read_data <= (bus.addr == 2'd0) ? id_val : result_val;
    else
      bus.read_data <= '0;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // transaction log plus bus-rule checks, sampled mid-cycle
  always @(negedge clk) begin
    logic [2:0] viol;
    viol[0] = bus.write & bus.read;
    viol[1] = ~bus.cs & ((bus.addr != 2'd0) | (bus.write_data != 32'd0));
    viol[2] = bus.cs ^ (bus.read | bus.write);
    chk("bus_rule", 64'(viol), 64'd0);
    if (bus.cs) lg.push_back('{bus.write, bus.read, bus.addr, bus.write_data, cyc});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int h;
    int first;
    int bad;
    logic [35:0] exp_tr [5];

    // reset state
    repeat (3) tick();
    chk("rst_cs",     64'(bus.cs),     64'd0);
    chk("rst_mvalid", 64'(m_valid),    64'd0);
    chk("rst_sready", 64'(s_ready),    64'd0);
    chk("rst_cready", 64'(coef_ready), 64'd0);
    chk("rst_idok",   64'(id_ok),      64'd0);
    chk("rst_iderr",  64'(id_err),     64'd0);

    // ID probe passes
    reset = 1'b0;
    tick();
    chk("idreq_rd",   64'({bus.cs, bus.read, bus.write}), 64'b110);
    chk("idreq_addr", 64'(bus.addr), 64'd0);
    tick();
    chk("idwait_cs",  64'(bus.cs), 64'd0);
    chk("idwait_ok",  64'(id_ok),  64'd0);
    tick();
    chk("idpass_ok",     64'(id_ok),      64'd1);
    chk("idpass_err",    64'(id_err),     64'd0);
    chk("idpass_sready", 64'(s_ready),    64'd1);
    chk("idpass_cready", 64'(coef_ready), 64'd1);

    // coefficient has priority over a simultaneous sample
    lg.delete();
    coef_valid = 1'b1; coef_data = 32'h3;
    s_valid    = 1'b1; s_data    = 32'h5;
    tick();
    coef_valid = 1'b0;
    chk("wrcoef_cready", 64'(coef_ready), 64'd0);
    tick();
    chk("idle_sready", 64'(s_ready), 64'd1);
    h = cyc;
    tick();
    s_valid = 1'b0;
    first = -1;
    bad = 0;
    for (int i = 0; i < 30 && first < 0; i++) begin
      if (m_valid) first = cyc;
      else begin
        if (s_ready) bad++;
        tick();
      end
    end
    chk("latency",      64'(first - h), 64'd10);
    chk("busy_sready",  64'(bad),       64'd0);
    chk("log_size",     64'(lg.size()), 64'd5);
    while (lg.size() < 5) lg.push_back('{1'b0, 1'b0, 2'd0, 32'd0, 0});
    exp_tr[0] = {1'b1, 1'b0, 2'd0, 32'h3};
    exp_tr[1] = {1'b1, 1'b0, 2'd1, 32'h5};
    exp_tr[2] = {1'b1, 1'b0, 2'd2, 32'h1};
    exp_tr[3] = {1'b0, 1'b1, 2'd1, 32'h0};
    exp_tr[4] = {1'b1, 1'b0, 2'd2, 32'h0};
    for (int i = 0; i < 5; i++)
      chk($sformatf("tr%0d", i), 64'({lg[i].w, lg[i].r, lg[i].a, lg[i].d}), 64'(exp_tr[i]));
    chk("wrx_cycle",  64'(lg[1].c - h),        64'd1);
    chk("wait_gap",   64'(lg[3].c - lg[2].c),  64'd5);
    chk("ctrloff_cy", 64'(lg[4].c - h),        64'd9);

    // result backpressure: data held, no new sample taken
    s_valid = 1'b1; s_data = 32'h9;
    for (int i = 0; i < 10; i++) begin
      chk("bp_mvalid", 64'(m_valid), 64'd1);
      chk("bp_mdata",  64'(m_data),  64'h1234);
      chk("bp_sready", 64'(s_ready), 64'd0);
      tick();
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    chk("hs_mvalid", 64'(m_valid), 64'd1);
    chk("hs_sready", 64'(s_ready), 64'd0);
    tick();
    m_ready = 1'b0;
    chk("post_hs_mvalid", 64'(m_valid), 64'd0);
    chk("post_hs_sready", 64'(s_ready), 64'd1);

    // reset while waiting on the FIR
    result_val = 32'hABCD;
    s_valid = 1'b1; s_data = 32'h7;
    tick();
    s_valid = 1'b0;
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("rw_strobes", 64'({bus.cs, bus.read, bus.write}), 64'd0);
    chk("rw_mvalid",  64'(m_valid), 64'd0);
    chk("rw_sready",  64'(s_ready), 64'd0);
    tick();
    reset = 1'b0;
    chk("rw_idok_clr", 64'(id_ok), 64'd0);
    tick();
    chk("rw_idreq",  64'({bus.cs, bus.read, bus.write}), 64'b110);
    chk("rw_idaddr", 64'(bus.addr), 64'd0);
    tick();
    tick();
    chk("rw_idok", 64'(id_ok), 64'd1);

    // ID probe fails: halted until reset
    id_val = 32'd7;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("idf_req", 64'({bus.cs, bus.read, bus.write}), 64'b110);
    tick();
    tick();
    chk("idf_err", 64'(id_err), 64'd1);
    chk("idf_ok",  64'(id_ok),  64'd0);
    coef_valid = 1'b1;
    s_valid    = 1'b1;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (s_ready || coef_ready || bus.cs) bad++;
      tick();
    end
    chk("halt_quiet",  64'(bad),    64'd0);
    chk("halt_sticky", 64'(id_err), 64'd1);
    coef_valid = 1'b0;
    s_valid    = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  // global time limit so the run always ends
  initial begin
    #100000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fir_bus_master.md
Name: fir_bus_master

Overview:
- Initiator-side counterpart of the FIR register slave. It drives the slave's cs/write/read/addr/write_data bus and captures its registered read_data.
- Converts a valid/ready sample stream and a coefficient stream into register transactions, then returns FIR results as a valid/ready stream.
- Sits between the streaming datapath and the memory-mapped FIR slave.
- After reset it probes the slave ID register before accepting any traffic.

Parameters:
- DATA_WIDTH, 32, width of bus data, samples, coefficients and results.
- FIR_LATENCY, 4, idle cycles between the control=1 write and the result read; minimum 1.
- EXPECTED_ID, 15, value the slave must return from addr 0.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- coef_valid  in  1  coefficient available
- coef_ready  out  1  coefficient accepted (handshake = valid & ready)
- coef_data  in  DATA_WIDTH  coefficient value
- s_valid  in  1  sample available
- s_ready  out  1  sample accepted
- s_data  in  DATA_WIDTH  sample value
- m_valid  out  1  result valid
- m_ready  in  1  downstream accepts result
- m_data  out  DATA_WIDTH  FIR result
- id_ok  out  1  ID probe matched (sticky)
- id_err  out  1  ID probe mismatched (sticky); block stays halted
- cs  out  1  bus chip select
- write  out  1  bus write strobe
- read  out  1  bus read strobe
- addr  out  2  bus address: 0=coef/ID, 1=x/result, 2=control
- write_data  out  DATA_WIDTH  bus write data
- read_data  in  DATA_WIDTH  slave read data, registered; valid the cycle after the read strobe

Behaviour:
- Reset: all outputs are 0 and state is ID_REQ. Reset is sampled on the clock edge; all strobes drop the cycle after it is seen, and any transaction in flight is abandoned.
- Bus rules:
  - At most one strobe per cycle; each strobe lasts exactly 1 cycle with cs=1.
  - write and read are never high together.
  - addr and write_data are 0 whenever cs=0.
- ID_REQ: cs=1, read=1, addr=0 for 1 cycle, then ID_WAIT.
- ID_WAIT: capture read_data.
  - Equal to EXPECTED_ID: set id_ok, go to IDLE.
  - Otherwise: set id_err, go to HALT.
  - HALT is left only by reset.
- IDLE: coef_ready and s_ready are combinationally 1 only in IDLE. Coefficient has priority when coef_valid and s_valid are both high.
  - Coefficient handshake: latch coef_data, go to WR_COEF.
  - Sample handshake: latch s_data, go to WR_X.
- WR_COEF: write addr 0 with the latched coefficient, return to IDLE.
- Per-sample sequence, one cycle per state unless noted:
  - WR_X: write addr 1 with the latched sample.
  - CTRL_ON: write addr 2 with data 1.
  - WAIT: count FIR_LATENCY cycles with a down-counter of width clog2(FIR_LATENCY+1).
  - RD_REQ: read addr 1.
  - RD_CAP: latch read_data into m_data.
  - CTRL_OFF: write addr 2 with data 0.
  - OUT: m_valid=1.
- OUT: m_data holds steady while m_valid=1 and m_ready=0. On m_valid & m_ready, return to IDLE with m_valid=0 the next cycle.
- Throughput: no new sample is accepted while a result is pending, so at most one sample is in flight.
- Minimum sample-to-result latency: 6 + FIR_LATENCY cycles from the s handshake to m_valid.
- Back-to-back samples: the earliest next s_ready is the cycle after the m handshake.

Decomposition:
- Shared package fir_bus_pkg:
  - register address constants ADDR_COEF=0, ADDR_X=1, ADDR_CTRL=2, ADDR_ID=0.
  - DEFAULT_ID=15.
  - state encoding enum: ID_REQ, ID_WAIT, HALT, IDLE, WR_COEF, WR_X, CTRL_ON, WAIT, RD_REQ, RD_CAP, CTRL_OFF, OUT.
- One natural sub-module, fir_bus_if: a registered bus-strobe generator taking a one-cycle op request (rd/wr, addr, data) and producing cs/read/write/addr/write_data. The FSM stays in the top.

Test Plan:
- ID pass: slave model returns 15 the cycle after the addr 0 read -> id_ok=1 on the following cycle, id_err=0, s_ready rises in IDLE.
- ID fail: model returns 7 -> id_err=1; s_ready and coef_ready stay 0 for 50 cycles; no further cs.
- Coefficient priority: coef_valid and s_valid both high with coef 0x3, sample 0x5 -> bus shows write addr0=0x3, then write addr1=0x5, addr2=1, 4 idle cycles, read addr1, addr2=0.
- Result backpressure: model returns 0x1234 and m_ready is held low for 10 cycles -> m_valid=1 and m_data=0x1234 stable throughout; s_ready=0 until the handshake.
- Latency check with FIR_LATENCY=4: s handshake at cycle 0 -> m_valid first high at cycle 10; a second sample is accepted no earlier than one cycle after the m handshake.
- Reset during WAIT -> the next cycle has cs=read=write=0 and m_valid=0, and an ID_REQ read of addr 0 is issued after reset deasserts.
